// File: rtl/ysyx_23060187_wbu.sv
// ysyx_23060187_wbu -- write-back unit.
//
// Receives one result packet at a time from the EXU over a valid/ready
// interface, performs an optional memory store over a write-address /
// write-data / write-response channel, writes the register file, and then
// signals retirement to the IFU. Single-issue: it never holds more than one
// packet and does not pipeline.
//
// Handshake rule (every channel here): a transfer happens on the rising clk
// edge where valid and ready are both 1. A valid, once raised, stays high
// with its payload stable until that edge, and drops in the following cycle.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   EXU_WBU_*                 incoming packet (valid/ready + reg and mem fields)
//   WBU_REG_wen/waddr/wdata   register-file write (1-cycle strobe)
//   WBU_MEM_aw*/w*/b*         store channel; wstrb is always 4'hf
//   WBU_IFU_valid/IFU_WBU_ready  retire handshake
//   WBU_err                   sticky bus-error flag
//
// Configuration macro: WBU_BRESP_CHECK_EN
//   defined   -> a non-OKAY bresp at the response handshake sets WBU_err,
//                which stays set until rst.
//   undefined -> bresp is ignored and WBU_err is tied to 0.
//
// FSM state is held in `state` (IDLE, MEM_REQ, MEM_RESP, COMMIT, RETIRE).
module ysyx_23060187_wbu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXU_WBU_valid,
  output logic              WBU_EXU_ready,
  input  logic              EXU_WBU_register_wen,
  input  logic [ADDR_W-1:0] EXU_WBU_register_waddr,
  input  logic [DATA_W-1:0] EXU_WBU_register_wdata,
  input  logic              EXU_WBU_memory_wen,
  input  logic [ADDR_W-1:0] EXU_WBU_memory_waddr,
  input  logic [DATA_W-1:0] EXU_WBU_memory_wdata,
  output logic              WBU_REG_wen,
  output logic [REG_AW-1:0] WBU_REG_waddr,
  output logic [DATA_W-1:0] WBU_REG_wdata,
  output logic              WBU_MEM_awvalid,
  input  logic              WBU_MEM_awready,
  output logic [ADDR_W-1:0] WBU_MEM_awaddr,
  output logic              WBU_MEM_wvalid,
  input  logic              WBU_MEM_wready,
  output logic [DATA_W-1:0] WBU_MEM_wdata,
  output logic [3:0]        WBU_MEM_wstrb,
  input  logic              WBU_MEM_bvalid,
  output logic              WBU_MEM_bready,
  input  logic [1:0]        WBU_MEM_bresp,
  output logic              WBU_IFU_valid,
  input  logic              IFU_WBU_ready,
  output logic              WBU_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_REQ  = 3'd1,
    S_MEM_RESP = 3'd2,
    S_COMMIT   = 3'd3,
    S_RETIRE   = 3'd4
  } state_e;

  state_e state;

  // Latched packet fields.
  logic              pkt_reg_wen;
  logic [REG_AW-1:0] pkt_reg_idx;
  logic [DATA_W-1:0] pkt_reg_data;
  logic [ADDR_W-1:0] pkt_mem_addr;
  logic [DATA_W-1:0] pkt_mem_data;

  // Which of the two request handshakes has already completed.
  logic aw_done;
  logic w_done;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign aw_hs = WBU_MEM_awvalid & WBU_MEM_awready;
  assign w_hs  = WBU_MEM_wvalid & WBU_MEM_wready;
  assign b_hs  = WBU_MEM_bvalid & WBU_MEM_bready;

  assign WBU_REG_waddr  = pkt_reg_idx;
  assign WBU_REG_wdata  = pkt_reg_data;
  assign WBU_MEM_awaddr = pkt_mem_addr;
  assign WBU_MEM_wdata  = pkt_mem_data;
  assign WBU_MEM_wstrb  = 4'hf;

  // Upper register-address bits carry no meaning for a REG_AW-bit regfile.
  logic unused_bits;
`ifdef WBU_BRESP_CHECK_EN
  assign unused_bits = &{1'b0, EXU_WBU_register_waddr[ADDR_W-1:REG_AW]};
`else
  assign unused_bits = &{1'b0, EXU_WBU_register_waddr[ADDR_W-1:REG_AW], WBU_MEM_bresp};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      pkt_reg_wen     <= 1'b0;
      pkt_reg_idx     <= '0;
      pkt_reg_data    <= '0;
      pkt_mem_addr    <= '0;
      pkt_mem_data    <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      WBU_EXU_ready   <= 1'b1;
      WBU_REG_wen     <= 1'b0;
      WBU_MEM_awvalid <= 1'b0;
      WBU_MEM_wvalid  <= 1'b0;
      WBU_MEM_bready  <= 1'b0;
      WBU_IFU_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // WBU_EXU_ready is 1 throughout IDLE, so valid alone means a transfer.
          if (EXU_WBU_valid) begin
            pkt_reg_wen   <= EXU_WBU_register_wen;
            pkt_reg_idx   <= EXU_WBU_register_waddr[REG_AW-1:0];
            pkt_reg_data  <= EXU_WBU_register_wdata;
            pkt_mem_addr  <= EXU_WBU_memory_waddr;
            pkt_mem_data  <= EXU_WBU_memory_wdata;
            WBU_EXU_ready <= 1'b0;
            if (EXU_WBU_memory_wen) begin
              state           <= S_MEM_REQ;
              WBU_MEM_awvalid <= 1'b1;
              WBU_MEM_wvalid  <= 1'b1;
              aw_done         <= 1'b0;
              w_done          <= 1'b0;
            end else begin
              state       <= S_COMMIT;
              WBU_REG_wen <= EXU_WBU_register_wen &&
                             (EXU_WBU_register_waddr[REG_AW-1:0] != '0);
            end
          end
        end
        S_MEM_REQ: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            WBU_MEM_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_hs) begin
            WBU_MEM_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state          <= S_MEM_RESP;
            WBU_MEM_bready <= 1'b1;
          end
        end
        S_MEM_RESP: begin
          if (b_hs) begin
            WBU_MEM_bready <= 1'b0;
            state          <= S_COMMIT;
            WBU_REG_wen    <= pkt_reg_wen && (pkt_reg_idx != '0);
          end
        end
        S_COMMIT: begin
          WBU_REG_wen   <= 1'b0;
          WBU_IFU_valid <= 1'b1;
          state         <= S_RETIRE;
        end
        S_RETIRE: begin
          if (IFU_WBU_ready) begin
            WBU_IFU_valid <= 1'b0;
            WBU_EXU_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WBU_BRESP_CHECK_EN
  // Sticky: only rst clears it; the faulting instruction still retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WBU_err <= 1'b0;
    end else if (state == S_MEM_RESP && b_hs && WBU_MEM_bresp != 2'b00) begin
      WBU_err <= 1'b1;
    end
  end
`else
  assign WBU_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
module tb_ysyx_23060187_wbu;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              EXU_WBU_valid;
  logic              WBU_EXU_ready;
  logic              EXU_WBU_register_wen;
  logic [ADDR_W-1:0] EXU_WBU_register_waddr;
  logic [DATA_W-1:0] EXU_WBU_register_wdata;
  logic              EXU_WBU_memory_wen;
  logic [ADDR_W-1:0] EXU_WBU_memory_waddr;
  logic [DATA_W-1:0] EXU_WBU_memory_wdata;
  logic              WBU_REG_wen;
  logic [REG_AW-1:0] WBU_REG_waddr;
  logic [DATA_W-1:0] WBU_REG_wdata;
  logic              WBU_MEM_awvalid;
  logic              WBU_MEM_awready;
  logic [ADDR_W-1:0] WBU_MEM_awaddr;
  logic              WBU_MEM_wvalid;
  logic              WBU_MEM_wready;
  logic [DATA_W-1:0] WBU_MEM_wdata;
  logic [3:0]        WBU_MEM_wstrb;
  logic              WBU_MEM_bvalid;
  logic              WBU_MEM_bready;
  logic [1:0]        WBU_MEM_bresp;
  logic              WBU_IFU_valid;
  logic              IFU_WBU_ready;
  logic              WBU_err;

  ysyx_23060187_wbu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .EXU_WBU_valid          (EXU_WBU_valid),
    .WBU_EXU_ready          (WBU_EXU_ready),
    .EXU_WBU_register_wen   (EXU_WBU_register_wen),
    .EXU_WBU_register_waddr (EXU_WBU_register_waddr),
    .EXU_WBU_register_wdata (EXU_WBU_register_wdata),
    .EXU_WBU_memory_wen     (EXU_WBU_memory_wen),
    .EXU_WBU_memory_waddr   (EXU_WBU_memory_waddr),
    .EXU_WBU_memory_wdata   (EXU_WBU_memory_wdata),
    .WBU_REG_wen            (WBU_REG_wen),
    .WBU_REG_waddr          (WBU_REG_waddr),
    .WBU_REG_wdata          (WBU_REG_wdata),
    .WBU_MEM_awvalid        (WBU_MEM_awvalid),
    .WBU_MEM_awready        (WBU_MEM_awready),
    .WBU_MEM_awaddr         (WBU_MEM_awaddr),
    .WBU_MEM_wvalid         (WBU_MEM_wvalid),
    .WBU_MEM_wready         (WBU_MEM_wready),
    .WBU_MEM_wdata          (WBU_MEM_wdata),
    .WBU_MEM_wstrb          (WBU_MEM_wstrb),
    .WBU_MEM_bvalid         (WBU_MEM_bvalid),
    .WBU_MEM_bready         (WBU_MEM_bready),
    .WBU_MEM_bresp          (WBU_MEM_bresp),
    .WBU_IFU_valid          (WBU_IFU_valid),
    .IFU_WBU_ready          (IFU_WBU_ready),
    .WBU_err                (WBU_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic exp_err = 1'b0;   // reference sticky error flag

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    EXU_WBU_valid          = 1'b0;
    EXU_WBU_register_wen   = 1'b0;
    EXU_WBU_register_waddr = '0;
    EXU_WBU_register_wdata = '0;
    EXU_WBU_memory_wen     = 1'b0;
    EXU_WBU_memory_waddr   = '0;
    EXU_WBU_memory_wdata   = '0;
    WBU_MEM_awready        = 1'b0;
    WBU_MEM_wready         = 1'b0;
    WBU_MEM_bvalid         = 1'b0;
    WBU_MEM_bresp          = 2'b00;
    IFU_WBU_ready          = 1'b0;
  endtask

  // ---------------- driver + reference model ----------------
  // Sends one packet and plays EXU, memory slave and IFU for it. Cycle c is
  // the c-th cycle after the accepting edge; outputs are sampled at negedge.
  // Expected behaviour in reference terms:
  //   AW/W valid high from cycle 1 until their own handshake;
  //   bready high once both requests are done until the response handshake;
  //   commit one cycle after the response (or cycle 1 with no store),
  //   reg strobe only at commit and only for a nonzero index;
  //   IFU valid from commit+1 until IFU takes it; EXU ready low meanwhile.
  task automatic run_packet(input logic rwen, input logic [31:0] raddr,
                            input logic [31:0] rdata, input logic mwen,
                            input logic [31:0] maddr, input logic [31:0] mdata,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input int ifu_dly, input logic [1:0] bresp);
    int c, aw_hs_c, w_hs_c, b_hs_c, ret_c, commit_c, b_cnt, ifu_cnt, wait_cnt;
    logic exp_reg;
    exp_reg = rwen && (raddr[4:0] != 5'd0);

    wait_cnt = 0;
    while (!WBU_EXU_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("exu_ready_before_send", WBU_EXU_ready, 1'b1);

    EXU_WBU_valid          = 1'b1;
    EXU_WBU_register_wen   = rwen;
    EXU_WBU_register_waddr = raddr;
    EXU_WBU_register_wdata = rdata;
    EXU_WBU_memory_wen     = mwen;
    EXU_WBU_memory_waddr   = maddr;
    EXU_WBU_memory_wdata   = mdata;
    @(negedge clk);

    aw_hs_c = -1; w_hs_c = -1; b_hs_c = -1; ret_c = -1;
    b_cnt = 0; ifu_cnt = 0;
    for (c = 1; c <= 60 && ret_c < 0; c++) begin
      if (!mwen) commit_c = 1;
      else if (b_hs_c >= 0) commit_c = b_hs_c + 1;
      else commit_c = 1000;

      check("exu_ready_busy", WBU_EXU_ready, 1'b0);
      check("awvalid", WBU_MEM_awvalid, mwen && aw_hs_c < 0);
      check("wvalid", WBU_MEM_wvalid, mwen && w_hs_c < 0);
      if (WBU_MEM_awvalid) check("awaddr", WBU_MEM_awaddr, maddr);
      if (WBU_MEM_wvalid) begin
        check("wdata", WBU_MEM_wdata, mdata);
        check("wstrb", WBU_MEM_wstrb, 4'hf);
      end
      check("bready", WBU_MEM_bready, mwen && aw_hs_c >= 0 && w_hs_c >= 0 && b_hs_c < 0);
      check("reg_wen", WBU_REG_wen, exp_reg && c == commit_c);
      if (WBU_REG_wen) begin
        check("reg_waddr", WBU_REG_waddr, raddr[4:0]);
        check("reg_wdata", WBU_REG_wdata, rdata);
      end
      check("ifu_valid", WBU_IFU_valid, c > commit_c);
      check("err", WBU_err, exp_err);

      // Inputs for the coming edge; EXU keeps offering junk that must be ignored.
      EXU_WBU_valid          = 1'b1;
      EXU_WBU_register_wen   = 1'($urandom);
      EXU_WBU_register_waddr = $urandom;
      EXU_WBU_register_wdata = $urandom;
      EXU_WBU_memory_wen     = 1'($urandom);
      EXU_WBU_memory_waddr   = $urandom;
      EXU_WBU_memory_wdata   = $urandom;

      WBU_MEM_awready = (c > aw_dly);
      WBU_MEM_wready  = (c > w_dly);
      if (WBU_MEM_awvalid && WBU_MEM_awready && aw_hs_c < 0) aw_hs_c = c;
      if (WBU_MEM_wvalid && WBU_MEM_wready && w_hs_c < 0) w_hs_c = c;

      WBU_MEM_bvalid = 1'b0;
      WBU_MEM_bresp  = 2'b00;
      if (aw_hs_c >= 0 && aw_hs_c < c && w_hs_c >= 0 && w_hs_c < c && b_hs_c < 0) begin
        if (b_cnt >= b_dly) begin
          WBU_MEM_bvalid = 1'b1;
          WBU_MEM_bresp  = bresp;
        end
        b_cnt++;
      end
      if (WBU_MEM_bvalid && WBU_MEM_bready) begin
        b_hs_c = c;
`ifdef WBU_BRESP_CHECK_EN
        if (bresp != 2'b00) exp_err = 1'b1;
`endif
      end

      IFU_WBU_ready = 1'b0;
      if (WBU_IFU_valid) begin
        IFU_WBU_ready = (ifu_cnt >= ifu_dly);
        ifu_cnt++;
        if (IFU_WBU_ready) begin
          ret_c = c;
          EXU_WBU_valid = 1'b0;
        end
      end
      @(negedge clk);
    end

    if (ret_c < 0) begin
      check("retire_timeout", 1'b0, 1'b1);
      idle_inputs();
    end else begin
      IFU_WBU_ready = 1'b0;
      WBU_MEM_awready = 1'b0;
      WBU_MEM_wready = 1'b0;
      check("exu_ready_after_retire", WBU_EXU_ready, 1'b1);
      check("ifu_valid_after_retire", WBU_IFU_valid, 1'b0);
      check("reg_wen_after_retire", WBU_REG_wen, 1'b0);
      check("err_after_retire", WBU_err, exp_err);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [1:0]  br;
    idle_inputs();
    repeat (2) @(negedge clk);

    check("rst_exu_ready", WBU_EXU_ready, 1'b1);
    check("rst_reg_wen", WBU_REG_wen, 1'b0);
    check("rst_reg_waddr", WBU_REG_waddr, 5'd0);
    check("rst_reg_wdata", WBU_REG_wdata, 32'd0);
    check("rst_awvalid", WBU_MEM_awvalid, 1'b0);
    check("rst_awaddr", WBU_MEM_awaddr, 32'd0);
    check("rst_wvalid", WBU_MEM_wvalid, 1'b0);
    check("rst_wdata", WBU_MEM_wdata, 32'd0);
    check("rst_wstrb", WBU_MEM_wstrb, 4'hf);
    check("rst_bready", WBU_MEM_bready, 1'b0);
    check("rst_ifu_valid", WBU_IFU_valid, 1'b0);
    check("rst_err", WBU_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ALU write to x5, IFU ready at once.
    run_packet(1'b1, 32'd5, 32'h1234, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 2'b00);
    // x0 write suppressed, still retires.
    run_packet(1'b1, 32'd0, 32'hdead, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 2'b00);
    // Store with late AW, immediate W.
    run_packet(1'b0, 32'd7, 32'h0, 1'b1, 32'h80000010, 32'hcafef00d, 3, 0, 0, 0, 2'b00);
    // Store with late W, then same-cycle handshakes, plus reg write after store.
    run_packet(1'b1, 32'd9, 32'h55aa, 1'b1, 32'h80000020, 32'h11112222, 0, 2, 1, 0, 2'b00);
    run_packet(1'b1, 32'd31, 32'h77, 1'b1, 32'h80000024, 32'h3333, 1, 1, 2, 1, 2'b00);
    // IFU stalls for 4 cycles.
    run_packet(1'b1, 32'd3, 32'h4444, 1'b0, 32'h0, 32'h0, 0, 0, 0, 4, 2'b00);
    // Error response, then OKAY stores: flag sticks when the check is built in.
    run_packet(1'b0, 32'd0, 32'h0, 1'b1, 32'h80000030, 32'h1, 0, 0, 0, 0, 2'b10);
    run_packet(1'b0, 32'd0, 32'h0, 1'b1, 32'h80000034, 32'h2, 0, 0, 0, 0, 2'b00);
    run_packet(1'b1, 32'd4, 32'h3, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 2'b00);

    // Reset in the middle of a store request.
    EXU_WBU_valid        = 1'b1;
    EXU_WBU_memory_wen   = 1'b1;
    EXU_WBU_memory_waddr = 32'h80000040;
    EXU_WBU_memory_wdata = 32'h0badf00d;
    @(negedge clk);
    EXU_WBU_valid = 1'b0;
    check("mid_store_awvalid", WBU_MEM_awvalid, 1'b1);
    check("mid_store_wvalid", WBU_MEM_wvalid, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_err = 1'b0;
    #1;
    check("async_rst_awvalid", WBU_MEM_awvalid, 1'b0);
    check("async_rst_wvalid", WBU_MEM_wvalid, 1'b0);
    check("async_rst_ifu_valid", WBU_IFU_valid, 1'b0);
    check("async_rst_err", WBU_err, 1'b0);
    check("async_rst_exu_ready", WBU_EXU_ready, 1'b1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_exu_ready", WBU_EXU_ready, 1'b1);
    check("post_rst_awvalid", WBU_MEM_awvalid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra[4:0] = 5'd0;
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_packet(1'($urandom), ra, $urandom, 1'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), br);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
